// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//
// Load/store initiator between the datapath and a word-addressed data memory.
// Takes one byte/halfword/word request at a time (valid/ready). It turns the
// byte address into a word index and drives the memory strobes. Sub-word
// stores use read-modify-write. A one-cycle response pulse returns load data,
// sign- or zero-extended.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : request handshake (ready only while idle)
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : loads: 1 = zero-extend, 0 = sign-extend
//   req_wdata           : right-aligned store data
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : load result (0 for stores/errors), held between responses
//   resp_err            : misaligned / out-of-range / illegal size
//   mem_address         : word index driven to memory
//   mem_write_data      : word written to memory
//   mem_read, mem_write : memory strobes (never both high)
//   mem_read_data       : combinational read data from memory
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [31:0] WORD_MASK = (32'd1 << DEPTH_LOG2) - 32'd1;

    state_e      state_q, state_d;

    // Captured request fields
    logic        write_q;
    logic [1:0]  lo_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] wdata_q;

    // Registered outputs
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem_address_q;
    logic [31:0] mem_write_data_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic        accept_s;
    logic        req_err_s;
    logic [31:0] word_idx_s;

    // Request legality: illegal size, misalignment, or address beyond the memory.
    function automatic logic addr_error(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if ((addr >> (DEPTH_LOG2 + 2)) != 32'd0) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lo,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lo, 3'b000};
        case (size)
            2'b00:   res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed lane of a memory word with the low bits of store data.
    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            2'b00:   mask = 32'h0000_00FF;
            2'b01:   mask = 32'h0000_FFFF;
            default: mask = 32'hFFFF_FFFF;
        endcase
        mask = mask << {lo, 3'b000};
        data = wdata << {lo, 3'b000};
        return (word & ~mask) | (data & mask);
    endfunction

    assign accept_s   = req_valid && req_ready_q;
    assign req_err_s  = addr_error(req_addr, req_size);
    assign word_idx_s = (req_addr >> 2) & WORD_MASK;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_err_s) begin
                        state_d = ST_RESP;
                    end else if (req_write && (req_size == 2'b10)) begin
                        state_d = ST_WRITE;
                    end else begin
                        // loads and sub-word stores both need the current word first
                        state_d = ST_READ;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (write_q) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Request capture, memory-side registers and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q          <= 1'b0;
            lo_q             <= 2'b00;
            size_q           <= 2'b00;
            unsigned_q       <= 1'b0;
            wdata_q          <= 32'd0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= 32'd0;
            mem_address_q    <= 32'd0;
            mem_write_data_q <= 32'd0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
        end else begin
            // Strobes/handshake follow the next state so they line up with it exactly.
            req_ready_q  <= (state_d == ST_IDLE);
            resp_valid_q <= (state_d == ST_RESP);
            mem_read_q   <= (state_d == ST_READ);
            mem_write_q  <= (state_d == ST_WRITE);

            if (accept_s) begin
                write_q    <= req_write;
                lo_q       <= req_addr[1:0];
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                wdata_q    <= req_wdata;
                resp_err_q <= req_err_s;
                if (req_err_s) begin
                    resp_rdata_q <= 32'd0;
                end else begin
                    // erroneous requests leave the memory-side pins untouched
                    mem_address_q <= word_idx_s;
                    if (req_write && (req_size == 2'b10)) begin
                        mem_write_data_q <= req_wdata;
                    end
                end
            end

            if (state_q == ST_READ) begin
                if (write_q) begin
                    mem_write_data_q <= lane_merge(mem_read_data, lo_q, size_q, wdata_q);
                end else begin
                    resp_rdata_q <= lane_extract(mem_read_data, lo_q, size_q, unsigned_q);
                end
            end

            if (state_q == ST_WRITE) begin
                resp_rdata_q <= 32'd0;
            end
        end
    end

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_err       = resp_err_q;
    assign resp_rdata     = resp_rdata_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// Testbench for lsu_mem_master: a word memory attached to the DUT plus a
// byte-array reference model. Directed cases followed by random requests.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    lsu_mem_master #(.DEPTH_LOG2(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT
    logic [31:0] mem [0:255];
    assign mem_read_data = mem[mem_address[7:0]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[7:0]] <= mem_write_data;
    end

    // Reference byte memory
    logic [7:0] ref_mem [0:1023];

    // Strobe monitor (only this process writes these)
    int rd_cnt = 0, wr_cnt = 0, addr_bad = 0, overlap = 0;
    int exp_idx = 0;
    always @(negedge clk) begin
        if (mem_read && mem_write) overlap++;
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if ((mem_read || mem_write) && (mem_address !== 32'(exp_idx))) addr_bad++;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'b11) || (s == 2'b01 && a[0]) || (s == 2'b10 && a[1:0] != 2'b00)
               || (a >= 32'd1024);
    endfunction

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s, input logic u);
        logic [31:0] v;
        int n;
        n = nbytes(s);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + 32'(i)]) << (8 * i));
        if (n < 4 && !u && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    // Issue one request, keep req_valid high with junk while busy, check the response.
    task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] s,
                          input logic u, input logic [31:0] d, input string tag);
        logic        e;
        logic [31:0] exp_rd;
        int          exp_lat, exp_r, exp_w;
        int          rd0, wr0, ab0, cyc, lat, busy_ready;
        e       = ref_err(a, s);
        exp_rd  = (e || w) ? 32'd0 : ref_load(a, s, u);
        exp_lat = e ? 1 : (!w) ? 2 : (s == 2'b10) ? 2 : 3;
        exp_r   = (e || (w && s == 2'b10)) ? 0 : 1;
        exp_w   = (!e && w) ? 1 : 0;
        if (!e && w) begin
            for (int i = 0; i < nbytes(s); i++) ref_mem[a + 32'(i)] = 8'(d >> (8 * i));
        end
        exp_idx = int'((a >> 2) & 32'h0000_00FF);

        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_size = s;
        req_unsigned = u; req_wdata = d;
        cyc = 0;
        while (!req_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rd0 = rd_cnt; wr0 = wr_cnt; ab0 = addr_bad;
        // requester keeps presenting something; it must be ignored while busy
        req_write = 1'($urandom); req_addr = $urandom_range(0, 1023); req_wdata = $urandom;
        req_size = 2'($urandom);
        lat = 0; busy_ready = 0;
        do begin
            @(negedge clk);
            lat++;
            if (req_ready) busy_ready++;
        end while (!resp_valid && lat < 8);
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_rdata"}, resp_rdata, exp_rd);
        check({tag, "_err"},   32'(resp_err), 32'(e));
        check({tag, "_busyrdy"}, 32'(busy_ready), 32'd0);
        check({tag, "_rdstb"}, 32'(rd_cnt - rd0), 32'(exp_r));
        check({tag, "_wrstb"}, 32'(wr_cnt - wr0), 32'(exp_w));
        check({tag, "_addr"},  32'(addr_bad - ab0), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, 32'(resp_valid), 32'd0);
        check({tag, "_idle"},  32'(req_ready), 32'd1);
        check({tag, "_hold"},  resp_rdata, exp_rd);
    endtask

    initial begin
        logic [31:0] wv, a;
        logic [1:0]  s;
        int          rv_seen, wr0, bad;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
        req_size = 2'b00; req_unsigned = 1'b0; req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) begin
            wv = $urandom;
            mem[i] = wv;
            for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = 8'(wv >> (8 * b));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_err",   32'(resp_err), 32'd0);
        check("rst_strb",  {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_addr",  mem_address, 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEAD_BEEF, "st_w");
        do_req(1'b0, 32'h10, 2'b10, 1'b0, 32'd0,         "ld_w");
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'h1122_3344, "st_w2");
        do_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_00A5, "st_b");
        check("rmw_byte_word", mem[4], 32'h1122_A544);
        do_req(1'b0, 32'h11, 2'b00, 1'b0, 32'd0, "ld_bs");
        do_req(1'b0, 32'h11, 2'b00, 1'b1, 32'd0, "ld_bu");
        do_req(1'b1, 32'h10, 2'b10, 1'b0, 32'h1122_3344, "st_w3");
        do_req(1'b1, 32'h12, 2'b01, 1'b0, 32'h0000_8001, "st_h");
        check("rmw_half_word", mem[4], 32'h8001_3344);
        do_req(1'b0, 32'h12, 2'b01, 1'b0, 32'd0, "ld_hs");
        do_req(1'b0, 32'h13, 2'b01, 1'b0, 32'd0, "err_h");
        do_req(1'b0, 32'h06, 2'b10, 1'b0, 32'd0, "err_w");
        do_req(1'b0, 32'h10, 2'b11, 1'b0, 32'd0, "err_sz");
        do_req(1'b0, 32'h400, 2'b00, 1'b0, 32'd0, "err_rng");
        do_req(1'b1, 32'h3FC, 2'b10, 1'b0, 32'h0BAD_F00D, "st_top");
        do_req(1'b0, 32'h3FF, 2'b00, 1'b0, 32'd0, "ld_top");

        // Reset during the READ of a byte store
        do_req(1'b1, 32'h20, 2'b10, 1'b0, 32'h1122_3344, "st_pre");
        exp_idx = 8;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h21; req_size = 2'b00;
        req_wdata = 32'h0000_00A5;
        wr0 = wr_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rr_inread", 32'(mem_read), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rr_ready", 32'(req_ready), 32'd1);
        check("rr_valid", 32'(resp_valid), 32'd0);
        check("rr_strb",  {30'd0, mem_read, mem_write}, 32'd0);
        check("rr_rdata", resp_rdata, 32'd0);
        check("rr_addr",  mem_address, 32'd0);
        check("rr_wdata", mem_write_data, 32'd0);
        check("rr_err",   32'(resp_err), 32'd0);
        rst_n = 1'b1;
        rv_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) rv_seen++;
        end
        check("rr_noresp", 32'(rv_seen), 32'd0);
        check("rr_nowrite", 32'(wr_cnt - wr0), 32'd0);
        check("rr_memword", mem[8], 32'h1122_3344);

        // Random requests against the reference model
        for (int n = 0; n < 120; n++) begin
            s = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 11) == 0) ? $urandom : 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (s == 2'b01) a[0] = 1'b0;
                if (s == 2'b10) a[1:0] = 2'b00;
            end
            do_req(1'($urandom), a, s, 1'($urandom), $urandom, "rnd");
        end

        bad = 0;
        for (int i = 0; i < 256; i++) begin
            wv = {ref_mem[4 * i + 3], ref_mem[4 * i + 2], ref_mem[4 * i + 1], ref_mem[4 * i]};
            if (mem[i] !== wv) bad++;
        end
        check("mem_image", 32'(bad), 32'd0);
        check("no_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store initiator that sits between the datapath and the word-addressed data memory. Accepts one byte/halfword/word request at a time over a valid/ready handshake, converts the byte address to a word index and drives the memory's `address`/`write_data`/`mem_read`/`mem_write` pins. Sub-word stores use read-modify-write. Returns load data, sign- or zero-extended, with a one-cycle response pulse.

## Interface
- `DEPTH_LOG2`, 8: log2 of the number of memory words (256); byte addresses ≥ 4·2^DEPTH_LOG2 are errors.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` out 32: load result; 0 for stores and errors; held until next response.
- `resp_err` out 1: misaligned, out-of-range or illegal size; valid with `resp_valid`.
- `mem_address` out 32: word index {zeros, req_addr[DEPTH_LOG2+1:2]}.
- `mem_write_data` out 32: word to write.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_read_data` in 32: memory read data (combinational from memory).

## Operation
- States: IDLE, READ, WRITE, RESP. Request fields captured on accept (`req_valid && req_ready`).
- Error check at accept: size 11; half with addr[0]=1; word with addr[1:0]≠0; addr[31:DEPTH_LOG2+2]≠0. Error → RESP with `resp_err`=1, no memory strobe.
- Load (any size): IDLE→READ→RESP. In READ `mem_read`=1; `mem_read_data` sampled at end of READ, lane-selected (little-endian: byte lane addr[1:0], half lane addr[1]) and extended per `req_unsigned`.
- Store word: IDLE→WRITE→RESP; `mem_write_data` = `req_wdata`.
- Store byte/half: IDLE→READ→WRITE→RESP. Word sampled in READ, target lane replaced with `req_wdata` low bits, merged word registered into `mem_write_data`; other lanes unchanged.
- RESP: `resp_valid`=1 one cycle, then IDLE.
- `mem_read` and `mem_write` never high together; both 0 in IDLE and RESP. Strobes and `mem_address`/`mem_write_data` decoded from registers only, no combinational path from `req_*`.
- `mem_address`/`mem_write_data` stable for the full strobe cycle and retain last value otherwise.
- Requests while not IDLE are ignored (`req_ready`=0); the requester holds them.

## Timing
- Reset (rst_n=0 at a rising edge): state IDLE; `req_ready`=1 after the edge; `resp_valid`, `resp_err`, `mem_read`, `mem_write`=0; `resp_rdata`, `mem_address`, `mem_write_data`=0.
- Accept at edge k. `resp_valid` high in cycle: k+1 for error, k+2 for load or word store, k+3 for sub-word store.
- `req_ready` re-asserts the cycle after RESP; back-to-back throughput = latency+1 cycles per request.
- Reset mid-operation aborts: no `resp_valid`. A write in WRITE state during the reset cycle may already have landed (memory is level-sensitive); no partial RMW is ever written from READ.
- Read-after-write to the same word: the second request's READ is at least two cycles after the WRITE and sees the new data.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → `mem_address`=4 during strobes; load `resp_rdata`=0xDEADBEEF, `resp_err`=0, response at k+2.
- Byte store 0xA5 @0x11 over word 0x11223344 → one READ then WRITE of 0x1122A544, response at k+3; signed byte load @0x11 → 0xFFFFFFA5; unsigned → 0x000000A5.
- Half store 0x8001 @0x12 → word 0x80013344 (lanes 0/1 preserved); signed half load @0x12 → 0xFFFF8001.
- Half load @0x13, word load @0x06, size 11, load @0x400 → each `resp_err`=1, `resp_rdata`=0, response at k+1, `mem_read`/`mem_write` never asserted.
- `req_valid` held high with new request during busy states → `req_ready`=0, second request accepted only after first `resp_valid`; strobes never overlap.
- Assert `rst_n`=0 during READ of a byte store → no WRITE strobe, no `resp_valid`, all outputs at reset values next cycle, memory word unchanged.
